// File: rtl/mux_arbiter_4b.sv
// Two-lane buffered round-robin arbiter: per-lane FIFOs feed one registered 4-bit output
// stream, with a burst-limited grant state machine choosing the source lane.
module mux_arbiter_4b #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BURST = 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] data_in0,
  input  logic       valid_0,
  input  logic [3:0] data_in1,
  input  logic       valid_1,
  input  logic       out_ready,
  output logic       full_0,
  output logic       full_1,
  output logic [3:0] data_out,
  output logic       valid_out,
  output logic       selector
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  logic [3:0]    mem_q    [2][DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [CW-1:0] cnt_q    [2];
  logic [3:0]    din      [2];

  logic [1:0]    push, pop, full, nonempty;
  logic          grant_vld, grant_lane;
  logic [3:0]    head;

  state_e        state_q;
  logic [BW-1:0] burst_q;
  logic          last_lane_q;

  always_comb begin
    din[0] = data_in0;
    din[1] = data_in1;
    for (int l = 0; l < 2; l++) begin
      full[l]     = (cnt_q[l] == CW'(DEPTH));
      nonempty[l] = (cnt_q[l] != '0);
    end
    // Full is taken from the current count, so a same-edge pop never frees room for a push.
    push[0] = valid_0 && !full[0];
    push[1] = valid_1 && !full[1];

    grant_vld  = |nonempty;
    grant_lane = 1'b0;
    if (&nonempty) begin
      unique case (state_q)
        StG0:    grant_lane = (burst_q == BW'(BURST));
        StG1:    grant_lane = (burst_q != BW'(BURST));
        default: grant_lane = ~last_lane_q;
      endcase
    end else begin
      grant_lane = nonempty[1];
    end

    pop[0] = out_ready && grant_vld && !grant_lane;
    pop[1] = out_ready && grant_vld &&  grant_lane;
    head   = mem_q[grant_lane][rd_ptr_q[grant_lane]];
  end

  assign full_0 = full[0];
  assign full_1 = full[1];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push[l]) wr_ptr_q[l] <= wr_ptr_q[l] + 1'b1;
        if (pop[l])  rd_ptr_q[l] <= rd_ptr_q[l] + 1'b1;
        if (push[l] && !pop[l]) begin
          cnt_q[l] <= cnt_q[l] + 1'b1;
        end else if (!push[l] && pop[l]) begin
          cnt_q[l] <= cnt_q[l] - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: pointers and counts guard against stale entries.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) mem_q[l][wr_ptr_q[l]] <= din[l];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StIdle;
      burst_q     <= '0;
      last_lane_q <= 1'b1;
      data_out    <= '0;
      valid_out   <= 1'b0;
      selector    <= 1'b0;
    end else if (out_ready) begin
      if (grant_vld) begin
        data_out    <= head;
        valid_out   <= 1'b1;
        selector    <= grant_lane;
        state_q     <= grant_lane ? StG1 : StG0;
        last_lane_q <= grant_lane;
        // Saturate at BURST; a lone busy lane keeps winning without overflowing the counter.
        if (state_q == (grant_lane ? StG1 : StG0)) begin
          burst_q <= (burst_q == BW'(BURST)) ? burst_q : burst_q + 1'b1;
        end else begin
          burst_q <= BW'(1);
        end
      end else begin
        valid_out <= 1'b0;
        state_q   <= StIdle;
        burst_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter_4b.sv
// Bench for mux_arbiter_4b: queue-based reference model checked every cycle, plus directed
// scenarios with literal expected words.
module tb_mux_arbiter_4b;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BURST = 2;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [3:0] data_in0 = '0, data_in1 = '0;
  logic       valid_0 = 1'b0, valid_1 = 1'b0, out_ready = 1'b0;
  logic       full_0, full_1, valid_out, selector;
  logic [3:0] data_out;

  int errors = 0;
  int checks = 0;

  mux_arbiter_4b #(.DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .data_in0 (data_in0),
    .valid_0  (valid_0),
    .data_in1 (data_in1),
    .valid_1  (valid_1),
    .out_ready(out_ready),
    .full_0   (full_0),
    .full_1   (full_1),
    .data_out (data_out),
    .valid_out(valid_out),
    .selector (selector)
  );

  always #5 clk = ~clk;

  // Reference model: two queues, the lane currently on a run (-1 = none) and its run length.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] m_data = '0;
  logic       m_valid = 1'b0, m_sel = 1'b0;
  int         run_lane = -1, run_len = 0, last = 1;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_data = '0; m_valid = 1'b0; m_sel = 1'b0;
    run_lane = -1; run_len = 0; last = 1;
  endtask

  task automatic model_edge();
    int s0, s1, lane;
    s0 = q0.size();
    s1 = q1.size();
    lane = -1;
    if (out_ready) begin
      if (s0 > 0 && s1 > 0) begin
        if (run_lane < 0)          lane = 1 - last;
        else if (run_len < BURST)  lane = run_lane;
        else                       lane = 1 - run_lane;
      end else if (s0 > 0) lane = 0;
      else if (s1 > 0)     lane = 1;
      if (lane < 0) begin
        m_valid = 1'b0; run_lane = -1; run_len = 0;
      end else begin
        m_data  = (lane == 1) ? q1.pop_front() : q0.pop_front();
        m_valid = 1'b1;
        m_sel   = (lane == 1);
        run_len = (run_lane == lane) ? run_len + 1 : 1;
        run_lane = lane;
        last = lane;
      end
    end
    if (valid_0 && s0 < DEPTH) q0.push_back(data_in0);
    if (valid_1 && s1 < DEPTH) q1.push_back(data_in1);
  endtask

  initial forever begin
    @(posedge clk or negedge reset_L);
    if (!reset_L) model_reset();
    else          model_edge();
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("model_data",  data_out,  m_data);
    check("model_valid", valid_out, m_valid);
    check("model_sel",   selector,  m_sel);
    check("model_full0", full_0,    int'(q0.size() == DEPTH));
    check("model_full1", full_1,    int'(q1.size() == DEPTH));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_word(input string name, input int d, input int s);
    check({name, "_valid"}, valid_out, 1);
    check({name, "_data"},  data_out,  d);
    check({name, "_sel"},   selector,  s);
  endtask

  task automatic expect_idle(input string name);
    check({name, "_valid"}, valid_out, 0);
  endtask

  task automatic do_reset();
    valid_0 = 1'b0; valid_1 = 1'b0; out_ready = 1'b0;
    reset_L = 1'b0;
    step();
    step();
    reset_L = 1'b1;
  endtask

  int pre0[4] = '{1, 2, 3, 4};
  int pre1[4] = '{9, 10, 11, 12};
  int fair_d[8] = '{1, 2, 9, 10, 3, 4, 11, 12};
  int fair_s[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int bp_d[5] = '{10, 3, 4, 11, 12};
  int bp_s[5] = '{1, 0, 0, 1, 1};

  task automatic preload();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_0 = 1'b1; valid_1 = 1'b1;
      data_in0 = 4'(pre0[i]); data_in1 = 4'(pre1[i]);
      step();
    end
    valid_0 = 1'b0; valid_1 = 1'b0;
    check("preload_full0", full_0, 1);
    check("preload_full1", full_1, 1);
  endtask

  initial begin
    step();
    do_reset();
    check("rst_valid", valid_out, 0);
    check("rst_data",  data_out,  0);
    check("rst_sel",   selector,  0);
    check("rst_full0", full_0,    0);
    check("rst_full1", full_1,    0);

    // Single lane: A, B, C pushed on consecutive edges.
    out_ready = 1'b1;
    valid_0 = 1'b1; data_in0 = 4'hA;
    step();
    expect_idle("single_lat");
    data_in0 = 4'hB;
    step();
    expect_word("single_a", 'hA, 0);
    data_in0 = 4'hC;
    step();
    expect_word("single_b", 'hB, 0);
    valid_0 = 1'b0;
    step();
    expect_word("single_c", 'hC, 0);
    step();
    expect_idle("single_end");
    check("single_hold", data_out, 'hC);

    // Fair arbitration from a fresh reset.
    do_reset();
    preload();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_word($sformatf("fair%0d", i), fair_d[i], fair_s[i]);
    end
    step();
    expect_idle("fair_end");

    // Backpressure: stall three cycles after word 9.
    do_reset();
    preload();
    out_ready = 1'b1;
    step(); expect_word("bp_1", 1, 0);
    step(); expect_word("bp_2", 2, 0);
    step(); expect_word("bp_9", 9, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_word($sformatf("bp_stall%0d", i), 9, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_word($sformatf("bp_resume%0d", i), bp_d[i], bp_s[i]);
    end
    step();
    expect_idle("bp_end");

    // Full / overflow on lane 1.
    do_reset();
    valid_1 = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      data_in1 = 4'(i);
      step();
    end
    check("ovf_full_after4", full_1, 1);
    data_in1 = 4'hF;
    step();
    valid_1 = 1'b0;
    check("ovf_full_hold", full_1, 1);
    out_ready = 1'b1;
    step();
    expect_word("ovf_5", 5, 1);
    check("ovf_full_fall", full_1, 0);
    step(); expect_word("ovf_6", 6, 1);
    step(); expect_word("ovf_7", 7, 1);
    step(); expect_word("ovf_8", 8, 1);
    step(); expect_idle("ovf_no_f");

    // Simultaneous push and pop with lane 0 holding two words.
    do_reset();
    valid_0 = 1'b1; data_in0 = 4'h1;
    step();
    data_in0 = 4'h2;
    step();
    data_in0 = 4'h7; out_ready = 1'b1;
    step();
    valid_0 = 1'b0;
    expect_word("pp_1", 1, 0);
    step(); expect_word("pp_2", 2, 0);
    step(); expect_word("pp_7", 7, 0);
    step(); expect_idle("pp_end");

    // Reset mid-stream with lane 0 still holding three words.
    do_reset();
    valid_0 = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      data_in0 = 4'(i);
      step();
    end
    valid_0 = 1'b0;
    out_ready = 1'b1;
    step();
    expect_word("mid_3", 3, 0);
    out_ready = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data",  data_out,  0);
    check("mid_rst_sel",   selector,  0);
    check("mid_rst_full0", full_0,    0);
    #1 reset_L = 1'b1;
    out_ready = 1'b1;
    step(); expect_idle("mid_after1");
    step(); expect_idle("mid_after2");

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_4b.md
# mux_arbiter_4b

Two-lane buffered round-robin arbiter for the 4-bit valid/data mux datapath. Each input lane (`data_in0`/`valid_0`, `data_in1`/`valid_1`) is captured into its own FIFO. A grant state machine decides which lane drives the registered output stream and exports that choice as `selector`. The block sits in front of the downstream consumer and replaces the free-running mux selector with a fair, backpressure-aware schedule.

## Interface
- `DEPTH`, default 4: entries per lane FIFO; power of two, minimum 2.
- `BURST`, default 2: maximum consecutive grants to one lane while the other lane is non-empty; minimum 1.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset_L`  input  1  asynchronous, active-low reset.
- `data_in0`  input  4  lane 0 data.
- `valid_0`  input  1  lane 0 push request.
- `data_in1`  input  4  lane 1 data.
- `valid_1`  input  1  lane 1 push request.
- `out_ready`  input  1  downstream can accept a word this cycle.
- `full_0`  output  1  lane 0 FIFO holds DEPTH entries.
- `full_1`  output  1  lane 1 FIFO holds DEPTH entries.
- `data_out`  output  4  registered output word.
- `valid_out`  output  1  `data_out` carries a new word.
- `selector`  output  1  lane that sourced the current `data_out`.

## Operation
- Reset (`reset_L`=0, asynchronous, no clock edge required):
  - `data_out`=0, `valid_out`=0, `selector`=0, `full_0`=`full_1`=0.
  - Both FIFOs empty; state IDLE; `burst_cnt`=0; `last_lane`=1, so lane 0 wins the first tie.
- Push:
  - At each edge, lane x writes `data_inx` when `valid_x`=1 and `full_x`=0.
  - A push while full is dropped silently and the FIFO is unchanged.
  - `full_x` is decoded from the current count, so a simultaneous pop does not admit a push into a full FIFO.
- Pointers and counts:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Push and pop on the same edge leave the count unchanged.
- Grant states: IDLE, G0, G1 (the lane granted at the last pop), plus `burst_cnt` in 0..BURST.
- At each edge with `out_ready`=1, choose a lane L:
  - Neither FIFO non-empty: no lane chosen.
  - Only one FIFO non-empty: that lane.
  - Both non-empty, in Gx with `burst_cnt` < BURST: lane x.
  - Both non-empty, in Gx with `burst_cnt` = BURST: the other lane.
  - Both non-empty, in IDLE: the lane != `last_lane`.
- If lane L is chosen:
  - Pop its head: `data_out`<=head, `valid_out`<=1, `selector`<=L.
  - State<=GL and `last_lane`<=L.
  - `burst_cnt`<=`burst_cnt`+1 if already in GL, else 1.
- If no lane is chosen: `valid_out`<=0; `data_out` and `selector` hold; state<=IDLE; `burst_cnt`<=0.
- At each edge with `out_ready`=0: no pop; `data_out`, `valid_out`, `selector`, state and `burst_cnt` all hold. Pushes still proceed.
- The word at the FIFO head is never lost or duplicated across stalls.

## Timing
- Latency from sampling `valid_x`=1 at edge N (lane empty, `out_ready`=1, other lane empty) to `valid_out`=1: the word is visible after edge N+1, i.e. 2 cycles.
- Throughput: one word per cycle while any lane is non-empty and `out_ready`=1.
- `full_x` rises in the cycle after the edge that writes the DEPTH-th entry.
- `full_x` falls in the cycle after the first pop from a full FIFO.
- A reset asserted mid-stream clears the outputs immediately.
  - On deassertion, the first edge resumes from the reset state.
  - No stale FIFO contents ever appear.
- All outputs are registered; none depends combinationally on the inputs.

## Test plan
- Reset mid-stream: with lane 0 holding 3 words, pull `reset_L` low between edges → `valid_out`, `data_out`, `selector`, `full_0` read 0 before the next edge; after release with no pushes, `valid_out` stays 0.
- Single lane: push 4'hA, 4'hB, 4'hC on lane 0 at consecutive edges with `out_ready`=1 → `data_out` = A, B, C on 3 consecutive cycles, starting 2 cycles after A is sampled; `selector`=0 throughout.
- Fair arbitration (DEPTH=4, BURST=2): preload lane 0 with {1,2,3,4} and lane 1 with {9,A,B,C} under `out_ready`=0, then set `out_ready`=1 → output order 1,2,9,A,3,4,B,C, with `selector` 0,0,1,1,0,0,1,1, then `valid_out`=0.
- Full/overflow: with `out_ready`=0, push 5,6,7,8,F on lane 1 → `full_1`=1 after the 4th push and F is dropped; drain → exactly 5,6,7,8, and `full_1` falls after the first pop.
- Backpressure: during the stream of scenario 3, drop `out_ready` for 3 cycles after the word 9 → `data_out`=9, `selector`=1, `valid_out` held steady; resuming gives A,3,4,B,C with nothing lost.
- Simultaneous push/pop: lane 0 count 2, push 4'h7 while popping → count stays 2; 4'h7 emerges after the remaining two older words.
